// File: rtl/audio_capture_buffer.sv
// Audio capture buffer: synchronizes SPI byte events, waits for an amplitude trigger,
// then stores a fixed-length utterance and serves it through a registered read port.
module audio_capture_buffer #(
  parameter int unsigned DEPTH  = 2000,
  parameter int unsigned AW     = 11,
  parameter int unsigned THRESH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic [7:0]    rx_byte,
  input  logic          rx_toggle,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW:0]   sample_count,
  output logic          triggered,
  output logic          done,
  output logic          overrun
);

  localparam int unsigned MW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DepthW  = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneW    = (AW+1)'(1);
  localparam logic [7:0]  ThreshW = 8'(THRESH);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  state_e        state;
  logic          s1, s2, s3;
  logic          ev;
  logic [7:0]    mag;
  logic          trig;
  logic          we;
  logic [MW-1:0] wr_addr;
  logic [7:0]    mem [DEPTH];

  // rx_byte needs no synchronizer: it has settled long before ev fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= rx_toggle;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign ev = s2 ^ s3;

  always_comb begin
    if (rx_byte >= 8'd128) mag = rx_byte - 8'd128;
    else                   mag = 8'd128 - rx_byte;
  end

  assign trig = (mag >= ThreshW);

  always_comb begin
    we      = 1'b0;
    wr_addr = sample_count[MW-1:0];
    if (arm && ev) begin
      unique case (state)
        StArmed: begin
          we      = trig;
          wr_addr = '0;
        end
        StCapture: we = 1'b1;
        default:   we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      sample_count <= '0;
      triggered    <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (arm) begin
            state        <= StArmed;
            sample_count <= '0;
            triggered    <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
          end
        end
        StArmed: begin
          if (!arm) begin
            state <= StIdle;
          end else if (ev && trig) begin
            sample_count <= OneW;
            triggered    <= 1'b1;
            if (DepthW == OneW) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              state <= StCapture;
            end
          end
        end
        StCapture: begin
          if (!arm) begin
            state <= StIdle;
          end else if (ev) begin
            sample_count <= sample_count + OneW;
            if (sample_count + OneW == DepthW) begin
              state <= StDone;
              done  <= 1'b1;
            end
          end
        end
        StDone: begin
          if (!arm)    state   <= StIdle;
          else if (ev) overrun <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= rx_byte;
  end

  // Out-of-range addresses read as zero; a same-cycle write returns the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 8'd0;
    end else if ({1'b0, rd_addr} < DepthW) begin
      rd_data <= mem[rd_addr[MW-1:0]];
    end else begin
      rd_data <= 8'd0;
    end
  end

endmodule

// File: tb/tb_audio_capture_buffer.sv
// Bench for audio_capture_buffer: directed scenarios plus random sessions checked
// against a queue-free array model of the capture rules.
module tb_audio_capture_buffer;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = 4;
  localparam int unsigned THRESH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0;
  logic [7:0]    rx_byte = 8'd0;
  logic          rx_toggle = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic [AW:0]   sample_count;
  logic          triggered;
  logic          done;
  logic          overrun;
  logic [AW+3:0] status;

  audio_capture_buffer #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .THRESH (THRESH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .rx_byte      (rx_byte),
    .rx_toggle    (rx_toggle),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .sample_count (sample_count),
    .triggered    (triggered),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  assign status = {sample_count, triggered, done, overrun};

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model of one capture session
  int m_cnt;
  bit m_trig, m_done, m_ovr, m_active;
  int m_mem [DEPTH];

  function automatic int magof(input int b);
    return (b >= 128) ? b - 128 : 128 - b;
  endfunction

  function automatic logic [AW+3:0] exp_status();
    return {(AW+1)'(m_cnt), m_trig, m_done, m_ovr};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_trig = 0; m_done = 0; m_ovr = 0; m_active = 0;
  endtask

  task automatic model_byte(input int b);
    if (m_active) begin
      if (m_done) begin
        m_ovr = 1;
      end else if (m_trig || magof(b) >= int'(THRESH)) begin
        m_mem[m_cnt] = b;
        m_cnt++;
        m_trig = 1;
        if (m_cnt == int'(DEPTH)) m_done = 1;
      end
    end
  endtask

  task automatic set_arm(input bit v);
    @(negedge clk);
    arm = v;
    repeat (2) @(negedge clk);
    if (v && !m_active) begin
      m_active = 1; m_cnt = 0; m_trig = 0; m_done = 0; m_ovr = 0;
    end
    if (!v) m_active = 0;
  endtask

  task automatic send_byte(input int b);
    @(negedge clk);
    rx_byte   = 8'(b);
    rx_toggle = ~rx_toggle;
    repeat (6) @(negedge clk);
    model_byte(b);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (status !== '0) begin
      n_fail++; $display("FAIL reset_status got %h want 0", status);
    end
    n_cmp++;
    if (rd_data !== 8'd0) begin
      n_fail++; $display("FAIL reset_rd_data got %0d want 0", rd_data);
    end
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_plan_capture();
    int seq [7] = '{100, 5, 7, 9, 11, 13, 15};
    int expv [8] = '{100, 5, 7, 9, 11, 13, 15, 17};
    bit seen;
    set_arm(1);
    send_byte(128); send_byte(130); send_byte(140);
    n_cmp++;
    if (status !== exp_status() || status !== '0) begin
      n_fail++; $display("FAIL silence_discard got %h want %h", status, exp_status());
    end
    foreach (seq[i]) send_byte(seq[i]);
    n_cmp++;
    if (status !== {5'd7, 3'b100}) begin
      n_fail++; $display("FAIL seven_written got %h want %h", status, {5'd7, 3'b100});
    end
    // Eighth byte: done must appear together with the final count
    @(negedge clk);
    rx_byte   = 8'd17;
    rx_toggle = ~rx_toggle;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (sample_count == (AW+1)'(DEPTH)) begin
        seen = 1;
        n_cmp++;
        if (done !== 1'b1) begin
          n_fail++; $display("FAIL done_timing got %b want 1", done);
        end
      end
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL final_write_timeout got count %0d want %0d", sample_count, DEPTH);
    end
    repeat (2) @(negedge clk);
    model_byte(17);
    n_cmp++;
    if (status !== exp_status()) begin
      n_fail++; $display("FAIL plan_full got %h want %h", status, exp_status());
    end
    for (int a = 0; a < int'(DEPTH); a++) begin
      @(negedge clk); rd_addr = AW'(a);
      @(negedge clk);
      n_cmp++;
      if (rd_data !== 8'(expv[a])) begin
        n_fail++; $display("FAIL plan_mem[%0d] got %0d want %0d", a, rd_data, expv[a]);
      end
    end
  endtask

  task automatic test_overrun();
    send_byte(200);
    n_cmp++;
    if (status !== {5'd8, 3'b111} || status !== exp_status()) begin
      n_fail++; $display("FAIL overrun got %h want %h", status, {5'd8, 3'b111});
    end
    @(negedge clk); rd_addr = 4'd7;
    @(negedge clk);
    n_cmp++;
    if (rd_data !== 8'd17) begin
      n_fail++; $display("FAIL overrun_mem7 got %0d want 17", rd_data);
    end
  endtask

  task automatic test_read();
    int addrs [3] = '{3, 9, 15};
    int want  [3] = '{9, 0, 0};
    foreach (addrs[i]) begin
      @(negedge clk); rd_addr = AW'(addrs[i]);
      @(negedge clk);
      n_cmp++;
      if (rd_data !== 8'(want[i])) begin
        n_fail++; $display("FAIL read_addr%0d got %0d want %0d", addrs[i], rd_data, want[i]);
      end
    end
  endtask

  task automatic test_trigger_boundary();
    set_arm(0);
    set_arm(1);
    n_cmp++;
    if (status !== '0) begin
      n_fail++; $display("FAIL rearm_clear got %h want 0", status);
    end
    send_byte(143);
    n_cmp++;
    if (status !== exp_status() || triggered !== 1'b0) begin
      n_fail++; $display("FAIL mag15_discard got %h want %h", status, exp_status());
    end
    send_byte(144);
    n_cmp++;
    if (status !== {5'd1, 3'b100}) begin
      n_fail++; $display("FAIL mag16_trigger got %h want %h", status, {5'd1, 3'b100});
    end
    @(negedge clk); rd_addr = '0;
    @(negedge clk);
    n_cmp++;
    if (rd_data !== 8'd144) begin
      n_fail++; $display("FAIL mag16_mem0 got %0d want 144", rd_data);
    end
  endtask

  task automatic test_disarm();
    send_byte(128); send_byte(60);
    set_arm(0);
    n_cmp++;
    if (status !== {5'd3, 3'b100}) begin
      n_fail++; $display("FAIL disarm_hold got %h want %h", status, {5'd3, 3'b100});
    end
    send_byte(250);
    n_cmp++;
    if (status !== exp_status()) begin
      n_fail++; $display("FAIL idle_drop got %h want %h", status, exp_status());
    end
    set_arm(1);
    n_cmp++;
    if (status !== '0) begin
      n_fail++; $display("FAIL rearm_after_disarm got %h want 0", status);
    end
  endtask

  task automatic test_async_reset();
    int tail [3] = '{240, 3, 128};
    send_byte(200); send_byte(1); send_byte(2); send_byte(128); send_byte(90);
    @(negedge clk); rd_addr = '0;
    @(negedge clk);
    n_cmp++;
    if (status !== exp_status() || sample_count !== 5'd5) begin
      n_fail++; $display("FAIL pre_reset_count got %h want %h", status, exp_status());
    end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if (status !== '0 || rd_data !== 8'd0) begin
      n_fail++; $display("FAIL async_reset got %h/%0d want 0/0", status, rd_data);
    end
    arm = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    set_arm(1);
    foreach (tail[i]) send_byte(tail[i]);
    n_cmp++;
    if (status !== exp_status() || sample_count !== 5'd3) begin
      n_fail++; $display("FAIL post_reset_session got %h want %h", status, exp_status());
    end
    foreach (tail[i]) begin
      @(negedge clk); rd_addr = AW'(i);
      @(negedge clk);
      n_cmp++;
      if (rd_data !== 8'(tail[i])) begin
        n_fail++; $display("FAIL post_reset_mem[%0d] got %0d want %0d", i, rd_data, tail[i]);
      end
    end
  endtask

  task automatic test_random();
    int b, n;
    for (int s = 0; s < 6; s++) begin
      set_arm(0);
      set_arm(1);
      n = int'($urandom_range(4, 14));
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 2))
          0:       b = int'($urandom_range(0, 255));
          1:       b = 128 - int'(THRESH) + 1 + int'($urandom_range(0, 2 * THRESH - 2));
          default: b = ($urandom_range(0, 1) == 1) ? 128 + int'(THRESH) : 128 - int'(THRESH);
        endcase
        send_byte(b);
      end
      n_cmp++;
      if (status !== exp_status()) begin
        n_fail++; $display("FAIL rand%0d_status got %h want %h", s, status, exp_status());
      end
      for (int a = 0; a < m_cnt; a++) begin
        @(negedge clk); rd_addr = AW'(a);
        @(negedge clk);
        n_cmp++;
        if (rd_data !== 8'(m_mem[a])) begin
          n_fail++; $display("FAIL rand%0d_mem[%0d] got %0d want %0d", s, a, rd_data, m_mem[a]);
        end
      end
      @(negedge clk); rd_addr = AW'($urandom_range(DEPTH, 2 ** AW - 1));
      @(negedge clk);
      n_cmp++;
      if (rd_data !== 8'd0) begin
        n_fail++; $display("FAIL rand%0d_oob addr %0d got %0d want 0", s, rd_addr, rd_data);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_plan_capture();
    test_overrun();
    test_read();
    test_trigger_boundary();
    test_disarm();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
